// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, rx state encoding, timing helpers.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_CHECK = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_e;

  // Bits needed to hold values 0..v-1 (at least 1 bit).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  // System clocks per serial bit.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Bit-period counter: counts 0..P_DIV-1, flags the half-period and full-period points.
module uart_rx_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned P_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic mid_o,
  output logic half_o
);

  localparam int unsigned   CW   = clog2(P_DIV);
  localparam logic [CW-1:0] LAST = CW'(P_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(P_DIV / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap at the end of a bit period; restart aligns the count to a new state.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == LAST)) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign mid_o  = (cnt_q == LAST);
  assign half_o = (cnt_q == HALF);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the line, samples each bit mid-period, and
// presents the word with parity/framing status on a one-cycle valid pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned P_SYSTEM_CLK      = 50_000_000,
  parameter int unsigned P_UART_BURD_RATE  = 9600,
  parameter int unsigned P_UART_DATA_WIDTH = 8,
  parameter int unsigned P_UART_CHECK_ON   = 1,
  parameter int unsigned P_UART_STOP_WIDTH = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_uart_rx,
  output logic                         o_user_rx_valid,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_check_err,
  output logic                         o_user_rx_frame_err
);

  localparam int unsigned   D         = baud_div(P_SYSTEM_CLK, P_UART_BURD_RATE);
  localparam int unsigned   W         = P_UART_DATA_WIDTH;
  localparam int unsigned   BW        = clog2(W + 1);
  localparam bit            HAS_PAR   = (P_UART_CHECK_ON != PAR_NONE);
  localparam logic [BW-1:0] DATA_LAST = BW'(W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(P_UART_STOP_WIDTH - 1);

  logic sync1_q, sync2_q, prev_q;
  logic fall;
  logic mid, half, mid_evt, restart;

  rx_state_e     state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [W-1:0]  shift_q, shift_d;
  logic          par_q, par_d;
  logic          cerr_q, cerr_d;
  logic          ferr_q, ferr_d;
  logic          valid_d;

  logic          valid_q;
  logic [W-1:0]  data_q;
  logic          cerr_out_q, ferr_out_q;

  // Two-flop synchronizer plus a history flop for start-edge detection; idles high.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;

  uart_rx_baud_cnt #(.P_DIV(D)) u_baud (
    .clk_i     (i_clk),
    .rst_ni    (i_rst),
    .restart_i (restart),
    .mid_o     (mid),
    .half_o    (half)
  );

  // The start bit is checked half a period in; everything after lands a full period later.
  assign mid_evt = (state_q == RX_START) ? half : mid;
  assign restart = (state_d != state_q);

  // Frame FSM next-state and datapath.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    cerr_d  = cerr_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          bit_d   = '0;
          par_d   = 1'b0;
          cerr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      RX_START: begin
        if (mid_evt) state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (mid_evt) begin
          shift_d = {sync2_q, shift_q[W-1:1]};
          par_d   = par_q ^ sync2_q;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? RX_CHECK : RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX_CHECK: begin
        if (mid_evt) begin
          cerr_d  = (P_UART_CHECK_ON == PAR_ODD) ? ~(par_q ^ sync2_q) : (par_q ^ sync2_q);
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (mid_evt) begin
          ferr_d = ferr_q | ~sync2_q;
          if (bit_q == STOP_LAST) begin
            // Back to IDLE right away so a start edge in the rest of this stop bit is caught.
            state_d = RX_IDLE;
            bit_d   = '0;
            valid_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= RX_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      cerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cerr_q  <= cerr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Output registers: valid pulses once, word and status hold until the next frame.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      cerr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (valid_d) begin
        data_q     <= shift_q;
        cerr_out_q <= HAS_PAR ? cerr_d : 1'b0;
        ferr_out_q <= ferr_d;
      end
    end
  end

  assign o_user_rx_valid     = valid_q;
  assign o_user_rx_data      = data_q;
  assign o_user_rx_check_err = cerr_out_q;
  assign o_user_rx_frame_err = ferr_out_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 and an 8O1 receiver, scoreboarded against frame-level expectations.
module tb_uart_rx;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] line = 2'b11;

  logic       v0, c0, f0, v1, c1, f1;
  logic [7:0] d0, d1;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] data;
    logic       cerr;
    logic       ferr;
    int         t0;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .P_SYSTEM_CLK(16), .P_UART_BURD_RATE(1), .P_UART_DATA_WIDTH(8),
    .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(1)
  ) u_dut_n (
    .i_clk(clk), .i_rst(rst_n), .i_uart_rx(line[0]),
    .o_user_rx_valid(v0), .o_user_rx_data(d0),
    .o_user_rx_check_err(c0), .o_user_rx_frame_err(f0)
  );

  uart_rx #(
    .P_SYSTEM_CLK(16), .P_UART_BURD_RATE(1), .P_UART_DATA_WIDTH(8),
    .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(1)
  ) u_dut_o (
    .i_clk(clk), .i_rst(rst_n), .i_uart_rx(line[1]),
    .o_user_rx_valid(v1), .o_user_rx_data(d1),
    .o_user_rx_check_err(c1), .o_user_rx_frame_err(f1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_frame(input string tag, input exp_t e, input logic [7:0] d,
                           input logic c, input logic f);
    check({tag, " data"}, 32'(d), 32'(e.data));
    check({tag, " check_err"}, 32'(c), 32'(e.cerr));
    check({tag, " frame_err"}, 32'(f), 32'(e.ferr));
    check({tag, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
  endtask

  // Monitors: every valid must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL n81 unexpected valid: got data %0h expected no valid", d0);
      end else begin
        e0 = q0.pop_front();
        cmp_frame("n81", e0, d0, c0, f0);
      end
    end
  end

  always @(negedge clk) begin
    if (v1 === 1'b1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL o81 unexpected valid: got data %0h expected no valid", d1);
      end else begin
        e1 = q1.pop_front();
        cmp_frame("o81", e1, d1, c1, f1);
      end
    end
  end

  task automatic drive(input int sel, input logic v, input int n);
    line[sel] = v;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic odd_pbit(input logic [7:0] d);
    return ~^d;
  endfunction

  // Issue one frame and record what a correct receiver must report for it.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic pbit,
                            input logic stopv);
    exp_t e;
    int   nb;
    nb     = (sel == 1) ? 11 : 10;
    e.data = data;
    // Odd parity: the data ones plus the parity bit must total an odd count.
    e.cerr = (sel == 1) && (($countones({data, pbit}) % 2) == 0);
    e.ferr = ~stopv;
    e.t0   = cyc;
    e.lat  = nb * D - D / 2 + 3;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
    drive(sel, 1'b0, D);
    for (int i = 0; i < 8; i++) drive(sel, data[i], D);
    if (sel == 1) drive(sel, pbit, D);
    drive(sel, stopv, D);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " n81 valid"}, 32'(v0), 32'd0);
    check({tag, " n81 data"}, 32'(d0), 32'd0);
    check({tag, " n81 check_err"}, 32'(c0), 32'd0);
    check({tag, " n81 frame_err"}, 32'(f0), 32'd0);
    check({tag, " o81 valid"}, 32'(v1), 32'd0);
    check({tag, " o81 data"}, 32'(d1), 32'd0);
    check({tag, " o81 check_err"}, 32'(c1), 32'd0);
    check({tag, " o81 frame_err"}, 32'(f1), 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, " outstanding frames"}, 32'(q0.size() + q1.size()), 32'd0);
    q0.delete();
    q1.delete();
    repeat (2 * D) @(negedge clk);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       pb, sv;
    int         sel, gap;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2 * D) @(negedge clk);

    // 8N1 basic frame
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    wait_drain("8n1 a5");

    // Odd parity: correct, then wrong parity bit
    send_frame(1, 8'h03, 1'b1, 1'b1);
    send_frame(1, 8'h03, 1'b0, 1'b1);
    wait_drain("odd parity");

    // Short glitch is rejected, next frame still received
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 2 * D);
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    wait_drain("glitch");

    // Bad stop bit then a long break: one frame error, no repeats
    send_frame(0, 8'h81, 1'b0, 1'b0);
    drive(0, 1'b0, 40 * D);
    drive(0, 1'b1, 2 * D);
    send_frame(0, 8'h42, 1'b0, 1'b1);
    wait_drain("break");

    // Back-to-back frames without idle
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    wait_drain("back2back");

    // Reset during data bit 4 aborts the frame silently
    drive(0, 1'b0, D);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, D);
    drive(0, 1'b0, D / 2);
    rst_n   = 1'b0;
    line[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("midreset");
    end
    rst_n = 1'b1;
    repeat (3 * D) @(negedge clk);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    wait_drain("after reset");

    // Random traffic on both receivers
    for (int k = 0; k < 30; k++) begin
      sel = int'($urandom_range(0, 1));
      rd  = 8'($urandom);
      pb  = ($urandom_range(0, 3) == 0) ? ~odd_pbit(rd) : odd_pbit(rd);
      sv  = ($urandom_range(0, 9) != 0);
      send_frame(sel, rd, pb, sv);
      gap = sv ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
      if (gap > 0) drive(sel, 1'b1, gap);
    end
    wait_drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
